// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a first-word-fall-through byte FIFO.
// Define RX_ERR_COUNT_EN to add the saturating err_count output.
module uart_rx_fifo #(
   parameter int RECEIVER_PERIOD = 646,
   parameter int FIFO_WIDTH      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        UART_RX,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overrun,
   output logic        framing_err
`ifdef RX_ERR_COUNT_EN
   ,
   output logic [15:0] err_count
`endif
);

   localparam int CNT_W = $clog2(2*RECEIVER_PERIOD);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(RECEIVER_PERIOD-1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2*RECEIVER_PERIOD-1);
   localparam int DEPTH = 2**FIFO_WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic             rx_meta_q, rx_s_q;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic             stop_ok, stop_bad;

   logic [FIFO_WIDTH:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]          mem_q [DEPTH];
   logic                empty, full, pop, push_ok;
   logic                overrun_q, framing_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      case (state_q)
         S_IDLE: if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
         end
         // Start bit is re-checked at mid-bit so short glitches fall back to idle.
         S_START: if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
         end else cnt_d = cnt_q + CNT_W'(1);
         S_DATA: if (cnt_q == FULL_LAST) begin
            cnt_d = '0;
            sh_d  = {rx_s_q, sh_q[7:1]};
            if (idx_q == 3'd7) state_d = S_STOP;
            else               idx_d   = idx_q + 3'd1;
         end else cnt_d = cnt_q + CNT_W'(1);
         S_STOP: if (cnt_q == FULL_LAST) begin
            cnt_d = '0;
            if (rx_s_q) begin
               stop_ok = 1'b1;
               state_d = S_IDLE;
            end else begin
               stop_bad = 1'b1;
               state_d  = S_BREAK;
            end
         end else cnt_d = cnt_q + CNT_W'(1);
         S_BREAK: if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign empty     = (rd_q == wr_q);
   assign full      = (rd_q[FIFO_WIDTH] != wr_q[FIFO_WIDTH]) &&
                      (rd_q[FIFO_WIDTH-1:0] == wr_q[FIFO_WIDTH-1:0]);
   assign pop       = !empty && out_ready;
   // A pop in the same cycle frees the slot the push lands in.
   assign push_ok   = stop_ok && (!full || pop);
   assign wr_d      = push_ok ? wr_q + 1'b1 : wr_q;
   assign rd_d      = pop ? rd_q + 1'b1 : rd_q;

   assign out_data    = mem_q[rd_q[FIFO_WIDTH-1:0]];
   assign out_valid   = !empty;
   assign overrun     = overrun_q;
   assign framing_err = framing_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         overrun_q <= 1'b0;
         framing_q <= 1'b0;
      end else begin
         rx_meta_q <= UART_RX;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         overrun_q <= stop_ok && !push_ok;
         framing_q <= stop_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[FIFO_WIDTH-1:0]] <= sh_q;
   end

`ifdef RX_ERR_COUNT_EN
   logic [15:0] err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= '0;
      else if ((overrun_q || framing_q) && err_q != 16'hFFFF)
         err_q <= err_q + 16'd1;
   end
   assign err_count = err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at RECEIVER_PERIOD=4 (8 clocks per bit).
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       UART_RX = 1'b1;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       overrun;
   logic       framing_err;
`ifdef RX_ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   uart_rx_fifo #(.RECEIVER_PERIOD(4), .FIFO_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .UART_RX(UART_RX),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun), .framing_err(framing_err)
`ifdef RX_ERR_COUNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Free-running monitor: pulse counters, valid-cycle counters, pop log.
   int         cyc = 0;
   int         ovr_n = 0, fe_n = 0, vld_n = 0, rise_cyc = -1;
   logic       prev_v = 1'b0;
   logic [7:0] popq [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (overrun)     ovr_n <= ovr_n + 1;
         if (framing_err) fe_n  <= fe_n + 1;
         if (out_valid)   vld_n <= vld_n + 1;
         if (out_valid && !prev_v) rise_cyc <= cyc;
         if (out_valid && out_ready) popq.push_back(out_data);
         prev_v <= out_valid;
      end else begin
         prev_v <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a posedge; returns #1 after a posedge with the line idle high.
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
      UART_RX = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         UART_RX = d[i];
         repeat (8) @(posedge clk);
         #1;
      end
      UART_RX = stop_v;
      repeat (8*stop_bits) @(posedge clk);
      #1;
      UART_RX = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0, b_ovr, b_fe, b_vld, b_pop;
      logic [7:0] exp_q [$];

      idle(3);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      check("reset_framing", {31'd0, framing_err}, 32'd0);
      rst = 1'b0;
      idle(4);

      // Single byte, consumer always ready
      out_ready = 1'b1;
      b_ovr = ovr_n; b_fe = fe_n; b_vld = vld_n; b_pop = popq.size();
      c0 = cyc;
      send_frame(8'hA5, 1'b1, 1);
      idle(4);
      check("a5_pops", popq.size() - b_pop, 1);
      check("a5_data", {24'd0, popq[b_pop]}, 32'hA5);
      check("a5_valid_cycles", vld_n - b_vld, 1);
      check("a5_valid_cycle_no", rise_cyc, c0 + 79);
      check("a5_no_overrun", ovr_n - b_ovr, 0);
      check("a5_no_framing", fe_n - b_fe, 0);

      // Two-cycle low glitch
      b_ovr = ovr_n; b_fe = fe_n; b_vld = vld_n;
      UART_RX = 1'b0;
      idle(2);
      UART_RX = 1'b1;
      idle(100);
      check("glitch_valid", vld_n - b_vld, 0);
      check("glitch_framing", fe_n - b_fe, 0);
      check("glitch_overrun", ovr_n - b_ovr, 0);

      // 17 bytes into a stalled consumer
      out_ready = 1'b0;
      b_ovr = ovr_n; b_pop = popq.size();
      for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1);
      idle(4);
      check("ovr_pulses", ovr_n - b_ovr, 1);
      out_ready = 1'b1;
      idle(20);
      check("ovr_drain_count", popq.size() - b_pop, 16);
      for (int i = 0; i < 16; i++)
         check($sformatf("ovr_drain_%0d", i), {24'd0, popq[b_pop + i]}, i);
      check("ovr_drain_empty", {31'd0, out_valid}, 32'd0);

      // Stop bit held low for three bit times, then a clean byte
      b_fe = fe_n; b_ovr = ovr_n; b_pop = popq.size();
      send_frame(8'h3C, 1'b0, 3);
      idle(16);
      check("fe_pulses", fe_n - b_fe, 1);
      check("fe_no_push", popq.size() - b_pop, 0);
      send_frame(8'h7E, 1'b1, 1);
      idle(4);
      check("fe_next_pops", popq.size() - b_pop, 1);
      check("fe_next_data", {24'd0, popq[b_pop]}, 32'h7E);
      check("fe_no_overrun", ovr_n - b_ovr, 0);
`ifdef RX_ERR_COUNT_EN
      check("err_count", {16'd0, err_count}, 2);
`endif

      // Full FIFO, single-cycle pop aligned with the push
      out_ready = 1'b0;
      b_ovr = ovr_n; b_pop = popq.size();
      for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, 1);
      fork
         send_frame(8'h99, 1'b1, 1);
         begin
            idle(78);
            out_ready = 1'b1;
            idle(1);
            out_ready = 1'b0;
         end
      join
      idle(4);
      check("full_pop_no_overrun", ovr_n - b_ovr, 0);
      out_ready = 1'b1;
      idle(24);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
      exp_q.push_back(8'h99);
      check("full_pop_count", popq.size() - b_pop, 17);
      for (int i = 0; i < 17; i++)
         check($sformatf("full_pop_%0d", i), {24'd0, popq[b_pop + i]}, {24'd0, exp_q[i]});

      // Reset mid-frame with a byte already queued
      out_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1);
      idle(2);
      check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
      UART_RX = 1'b0;
      idle(8);
      for (int i = 0; i < 3; i++) begin
         UART_RX = i[0] ? 1'b1 : 1'b0;
         idle(8);
      end
      UART_RX = 1'b1;
      idle(4);
      rst = 1'b1;
      idle(2);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_framing", {31'd0, framing_err}, 32'd0);
`ifdef RX_ERR_COUNT_EN
      check("rst_err_count", {16'd0, err_count}, 0);
`endif
      rst = 1'b0;
      idle(40);
      check("rst_fifo_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      b_pop = popq.size(); b_fe = fe_n;
      send_frame(8'h3C, 1'b1, 1);
      idle(4);
      check("rst_next_pops", popq.size() - b_pop, 1);
      check("rst_next_data", {24'd0, popq[b_pop]}, 32'h3C);
      check("rst_next_framing", fe_n - b_fe, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
